oled_refresh: RTL and testbench
===============================

// Module: oled_refresh
// PURPOSE
//  Downstream consumer of the CPU screen-read port. On each refresh request it reads the
//  256-byte CHIP-8 framebuffer (64x32, 1 bpp) through the scr_read/scr_read_ack handshake.
//  It scales the image 2x to 128x64 and streams it over 4-wire SPI to an SSD1306 OLED in
//  page-addressing layout. Display power-up init is handled elsewhere and signalled via oled_ready.
// PARAMETERS
//  CLK_DIV  2  clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)); legal range 1..255
// PORTS
//  clk            in   1  system clock
//  reset          in   1  asynchronous, active-high reset
//  refresh        in   1  1-cycle start pulse (e.g. tick_60hz)
//  oled_ready     in   1  display init finished; refresh is ignored while 0
//  scr_busy       out  1  high while a 32-byte page load is in progress (stalls CPU in NEXT)
//  scr_read       out  1  framebuffer read request
//  scr_read_idx   out  8  framebuffer byte index, row*8 + x/8
//  scr_read_byte  in   8  read data, valid when scr_read_ack=1
//  scr_read_ack   in   1  1-cycle read acknowledge
//  spi_sck        out  1  SPI clock, mode 0, idle low
//  spi_mosi       out  1  SPI data, MSB first
//  spi_cs_n       out  1  chip select, active low
//  spi_dc         out  1  0 = command byte, 1 = data byte
//  frame_done     out  1  1-cycle pulse after the last byte of a frame
// BEHAVIOUR
//  Reset (async, immediate): state IDLE. scr_busy=0, scr_read=0, scr_read_idx=0, spi_sck=0,
//   spi_mosi=0, spi_cs_n=1, spi_dc=0, frame_done=0. Reset mid-frame aborts the frame with no
//   further SPI edges and drops any outstanding read.
//  FSM: IDLE -> CMD -> {LOAD -> EMIT} x 8 pages -> DONE -> IDLE.
//  - IDLE: refresh && oled_ready starts a frame. The refresh pulse is ignored in every other state.
//  - CMD: spi_dc=0; send 21 00 7F 22 00 07 (column range 0..127, page range 0..7).
//  - LOAD page p (0..7): scr_busy=1; read idx = {p[2:0], i[4:0]}, i = 0..31, into a 32x8 line
//    buffer (CHIP-8 rows 4p..4p+3).
//    Handshake: scr_read and idx are registered and held until scr_read_ack is sampled high.
//    In that cycle, capture scr_read_byte and clear scr_read. Keep scr_read low for >=1 cycle
//    before the next request. There is no timeout: wait indefinitely for ack.
//    scr_busy drops on the cycle after the 32nd ack.
//  - EMIT page p: spi_dc=1; send 128 bytes for columns c = 0..127 with x = c>>1.
//    Bit k (k = 0 is the top row) = buf[(k>>1)*8 + (x>>3)] bit (7 - (x&7)).
//  - DONE: pulse frame_done for 1 cycle, then return to IDLE.
//  - A frame may tear between pages because the CPU runs during EMIT. This is accepted.
//  SPI serializer:
//   - spi_cs_n falls when CMD is entered. spi_mosi/spi_dc are set while SCK is low.
//   - SCK rises after CLK_DIV cycles and falls after another CLK_DIV cycles. A byte takes
//     16*CLK_DIV cycles.
//   - Bytes are sent back to back within a phase. spi_cs_n stays low through LOAD phases,
//     with SCK held low there.
//   - spi_cs_n rises CLK_DIV cycles after the final SCK fall, in the same cycle frame_done
//     pulses.
//  Totals: 6 command bytes + 1024 data bytes per frame. Counters: page 3b, load 5b,
//   column 7b, bit 3b, divider 8b. All counters wrap only under FSM control.
// TESTING
//  1. All-zero framebuffer, CLK_DIV=2, refresh -> 21 00 7F 22 00 07 with dc=0, then 1024 x 00
//     with dc=1, then one frame_done pulse and cs_n=1.
//  2. byte[0]=0x80 (pixel 0,0) -> page 0 columns 0,1 = 0x03; every other data byte = 0x00.
//  3. byte[255]=0x01 (pixel 63,31) -> page 7 columns 126,127 = 0xC0; byte[8]=0xFF -> page 0
//     columns 0..15 = 0x0C.
//  4. Model acks 5 cycles after request -> scr_read/idx stable until ack, >=1 low cycle
//     between reads, idx sequence 0..255, exactly 8 scr_busy windows of 32 acks each.
//  5. refresh mid-frame, or refresh with oled_ready=0 -> ignored: no extra frame and byte
//     count unchanged.
//  6. Assert reset during EMIT page 3 -> same cycle cs_n=1, sck=0, scr_read=0. Then a
//     refresh -> complete, correct frame from CMD.

Source files
------------

// File: rtl/oled_refresh.sv
// oled_refresh: reads the 64x32 CHIP-8 framebuffer one 32-byte page at a time,
// scales it 2x to 128x64 and streams it to an SSD1306 over 4-wire SPI (mode 0)
// in page-addressing layout. One frame = 6 command bytes + 8 x 128 data bytes.
module oled_refresh #(
    parameter logic [7:0] CLK_DIV = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh,
    input  logic       oled_ready,
    output logic       scr_busy,
    output logic       scr_read,
    output logic [7:0] scr_read_idx,
    input  logic [7:0] scr_read_byte,
    input  logic       scr_read_ack,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LOAD = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = CLK_DIV - 8'd1;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        read_q, read_d;
    logic [7:0]  idx_q, idx_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        dc_q, dc_d;
    logic        fd_q, fd_d;
    logic        act_q, act_d;      // a byte is on the wire
    logic [7:0]  div_q, div_d;      // SCK half-period divider
    logic [2:0]  bit_q, bit_d;      // bit position within the byte
    logic [7:0]  sh_q, sh_d;        // output shift register, MSB = current bit
    logic [2:0]  cmd_q, cmd_d;
    logic [2:0]  page_q, page_d;
    logic [4:0]  load_q, load_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  line_q [32];       // 4 CHIP-8 rows of the current page

    logic        byte_done_s;
    logic        load_byte_s;
    logic [7:0]  load_val_s;
    logic        line_we_s;
    logic [2:0]  cmd_sel_s;
    logic [6:0]  emit_col_s;
    logic [5:0]  emit_x_s;
    logic [7:0]  col_byte_s;

    // Command sequence: column range 0..127, page range 0..7.
    function automatic logic [7:0] cmd_byte(input logic [2:0] n);
        logic [7:0] v;
        case (n)
            3'd0:    v = 8'h21;
            3'd1:    v = 8'h00;
            3'd2:    v = 8'h7F;
            3'd3:    v = 8'h22;
            3'd4:    v = 8'h00;
            3'd5:    v = 8'h07;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Column byte for the next data byte: each source pixel covers 2 columns and 2 bit rows.
    always_comb begin
        emit_col_s = act_q ? (col_q + 7'd1) : col_q;
        emit_x_s   = emit_col_s[6:1];
        cmd_sel_s  = act_q ? (cmd_q + 3'd1) : cmd_q;
        col_byte_s = 8'h00;
        for (int j = 0; j < 4; j++) begin
            col_byte_s[2*j +: 2] = {2{line_q[{2'(j), emit_x_s[5:3]}][~emit_x_s[2:0]]}};
        end
    end

    // Next-state logic: SPI serializer, frame sequencing and framebuffer reads.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        read_d      = read_q;
        idx_d       = idx_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        dc_d        = dc_q;
        fd_d        = 1'b0;
        act_d       = act_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        cmd_d       = cmd_q;
        page_d      = page_q;
        load_d      = load_q;
        col_d       = col_q;
        byte_done_s = 1'b0;
        load_byte_s = 1'b0;
        load_val_s  = 8'h00;
        line_we_s   = 1'b0;

        // SCK toggles every CLK_DIV cycles; the next bit is presented on the falling edge.
        if (act_q) begin
            if (div_q == DIV_LAST) begin
                div_d = 8'd0;
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (bit_q == 3'd7) begin
                        byte_done_s = 1'b1;
                        act_d       = 1'b0;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        sh_d   = {sh_q[6:0], 1'b0};
                        mosi_d = sh_q[6];
                    end
                end else begin
                    sck_d = 1'b1;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end else begin
            act_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (refresh && oled_ready) begin
                    state_d = S_CMD;
                    cs_n_d  = 1'b0;
                    dc_d    = 1'b0;
                    cmd_d   = 3'd0;
                    page_d  = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (!act_q) begin
                    load_byte_s = 1'b1;
                    load_val_s  = cmd_byte(cmd_sel_s);
                end else if (byte_done_s) begin
                    if (cmd_q == 3'd5) begin
                        state_d = S_LOAD;
                        busy_d  = 1'b1;
                        load_d  = 5'd0;
                    end else begin
                        cmd_d       = cmd_q + 3'd1;
                        load_byte_s = 1'b1;
                        load_val_s  = cmd_byte(cmd_sel_s);
                    end
                end else begin
                    state_d = S_CMD;
                end
            end
            S_LOAD: begin
                if (read_q) begin
                    if (scr_read_ack) begin
                        line_we_s = 1'b1;
                        read_d    = 1'b0;
                        if (load_q == 5'd31) begin
                            state_d = S_EMIT;
                            busy_d  = 1'b0;
                            dc_d    = 1'b1;
                            col_d   = 7'd0;
                        end else begin
                            load_d = load_q + 5'd1;
                        end
                    end else begin
                        read_d = 1'b1;
                    end
                end else begin
                    // At least one idle cycle separates consecutive requests.
                    read_d = 1'b1;
                    idx_d  = {page_q, load_q};
                end
            end
            S_EMIT: begin
                if (!act_q) begin
                    load_byte_s = 1'b1;
                    load_val_s  = col_byte_s;
                end else if (byte_done_s) begin
                    if (col_q == 7'd127) begin
                        if (page_q == 3'd7) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                            page_d  = page_q + 3'd1;
                            busy_d  = 1'b1;
                            load_d  = 5'd0;
                        end
                    end else begin
                        col_d       = col_q + 7'd1;
                        load_byte_s = 1'b1;
                        load_val_s  = col_byte_s;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                // Hold CS low for one more half-period after the last SCK fall.
                if (div_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    fd_d    = 1'b1;
                    div_d   = 8'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                read_d  = 1'b0;
                act_d   = 1'b0;
                sck_d   = 1'b0;
            end
        endcase

        if (load_byte_s) begin
            sh_d   = load_val_s;
            mosi_d = load_val_s[7];
            bit_d  = 3'd0;
            div_d  = 8'd0;
            sck_d  = 1'b0;
            act_d  = 1'b1;
        end else begin
            sh_d = sh_d;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            read_q  <= 1'b0;
            idx_q   <= 8'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            fd_q    <= 1'b0;
            act_q   <= 1'b0;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            cmd_q   <= 3'd0;
            page_q  <= 3'd0;
            load_q  <= 5'd0;
            col_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            read_q  <= read_d;
            idx_q   <= idx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            fd_q    <= fd_d;
            act_q   <= act_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cmd_q   <= cmd_d;
            page_q  <= page_d;
            load_q  <= load_d;
            col_q   <= col_d;
        end
    end

    // Line buffer capture on each acknowledged read (contents need no reset).
    always_ff @(posedge clk) begin
        if (line_we_s) begin
            line_q[load_q] <= scr_read_byte;
        end
    end

    assign scr_busy     = busy_q;
    assign scr_read     = read_q;
    assign scr_read_idx = idx_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_dc       = dc_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_oled_refresh.sv
// Directed testbench for oled_refresh: framebuffer read responder, SPI byte
// decoder and per-scenario tasks with hand-computed expected bytes.
module tb_oled_refresh;

    localparam int ACK_DLY = 5;
    localparam int NBYTES  = 1030;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh = 1'b0;
    logic       oled_ready = 1'b0;
    logic       scr_busy, scr_read;
    logic [7:0] scr_read_idx;
    logic [7:0] scr_read_byte = 8'h00;
    logic       scr_read_ack = 1'b0;
    logic       spi_sck, spi_mosi, spi_cs_n, spi_dc, frame_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] fb [256];
    logic [7:0] cap_byte [NBYTES];
    logic       cap_dc [NBYTES];
    logic [7:0] cmd_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    int byte_cnt = 0, bit_n = 0, sck_rises = 0, spi_err = 0;
    int fd_cnt = 0, fd_cs_err = 0;
    int hs_err = 0, win_cnt = 0, win_acks = 0, ack_total = 0, exp_idx = 0, wcnt = 0;
    logic [7:0] shreg = 8'h00, lat_idx = 8'h00;
    logic prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;

    always #5 clk = ~clk;

    oled_refresh #(.CLK_DIV(8'd2)) dut (
        .clk(clk), .reset(reset), .refresh(refresh), .oled_ready(oled_ready),
        .scr_busy(scr_busy), .scr_read(scr_read), .scr_read_idx(scr_read_idx),
        .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_dc(spi_dc), .frame_done(frame_done)
    );

    // Responder and bus monitors, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (reset) begin
            scr_read_ack = 1'b0;
            wcnt = 0; exp_idx = 0; byte_cnt = 0; bit_n = 0;
            prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b0;
        end else begin
            if (!spi_cs_n && prev_cs) begin
                byte_cnt = 0;
                bit_n = 0;
            end
            if (spi_sck && !prev_sck) begin
                sck_rises++;
                if (spi_cs_n) spi_err++;
                shreg = {shreg[6:0], spi_mosi};
                bit_n++;
                if (bit_n == 8) begin
                    if (byte_cnt < NBYTES) begin
                        cap_byte[byte_cnt] = shreg;
                        cap_dc[byte_cnt] = spi_dc;
                    end
                    byte_cnt++;
                    bit_n = 0;
                end
            end
            if (frame_done) begin
                fd_cnt++;
                if (!spi_cs_n || prev_cs) fd_cs_err++;
                exp_idx = 0;
            end
            if (scr_read_ack) begin
                scr_read_ack = 1'b0;
                if (scr_read) hs_err++;
            end else if (scr_read) begin
                if (!scr_busy) hs_err++;
                if (wcnt == 0) begin
                    lat_idx = scr_read_idx;
                    if (scr_read_idx != exp_idx[7:0]) hs_err++;
                    exp_idx++;
                end else if (scr_read_idx != lat_idx) begin
                    hs_err++;
                end
                wcnt++;
                if (wcnt == ACK_DLY) begin
                    scr_read_ack = 1'b1;
                    scr_read_byte = fb[scr_read_idx];
                    wcnt = 0;
                    ack_total++;
                    win_acks++;
                end
            end
            if (scr_busy && !prev_busy) begin
                win_cnt++;
                win_acks = 0;
            end
            if (!scr_busy && prev_busy && win_acks != 32) hs_err++;
            prev_sck = spi_sck;
            prev_cs = spi_cs_n;
            prev_busy = scr_busy;
        end
    end

    task automatic pulse_refresh();
        @(negedge clk) refresh = 1'b1;
        @(negedge clk) refresh = 1'b0;
    endtask

    task automatic wait_fd(input int budget, output bit ok);
        int start;
        start = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (scr_busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got %b exp 0", scr_busy); end
        if (scr_read !== 1'b0)     begin failures++; $display("FAIL reset_read got %b exp 0", scr_read); end
        if (scr_read_idx !== 8'h00) begin failures++; $display("FAIL reset_idx got %h exp 00", scr_read_idx); end
        if (spi_sck !== 1'b0)      begin failures++; $display("FAIL reset_sck got %b exp 0", spi_sck); end
        if (spi_mosi !== 1'b0)     begin failures++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
        if (spi_cs_n !== 1'b1)     begin failures++; $display("FAIL reset_cs_n got %b exp 1", spi_cs_n); end
        if (spi_dc !== 1'b0)       begin failures++; $display("FAIL reset_dc got %b exp 0", spi_dc); end
        if (frame_done !== 1'b0)   begin failures++; $display("FAIL reset_fd got %b exp 0", frame_done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ready_low();
        int fd0, r0;
        oled_ready = 1'b0;
        fd0 = fd_cnt;
        r0 = sck_rises;
        pulse_refresh();
        repeat (100) @(negedge clk);
        checks += 3;
        if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL notready_cs_n got %b exp 1", spi_cs_n); end
        if (fd_cnt != fd0)     begin failures++; $display("FAIL notready_frames got %0d exp %0d", fd_cnt, fd0); end
        if (sck_rises != r0)   begin failures++; $display("FAIL notready_sck got %0d exp %0d", sck_rises, r0); end
        oled_ready = 1'b1;
    endtask

    task automatic test_zero_frame();
        int fd0;
        bit ok;
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        fd0 = fd_cnt;
        pulse_refresh();
        repeat (3000) @(negedge clk);
        pulse_refresh();   // must be ignored mid-frame
        wait_fd(45000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_frame_timeout got 0 exp 1"); end
        repeat (500) @(negedge clk);
        checks += 4;
        if (fd_cnt != fd0 + 1)   begin failures++; $display("FAIL zero_frame_count got %0d exp %0d", fd_cnt, fd0 + 1); end
        if (byte_cnt != NBYTES)  begin failures++; $display("FAIL zero_byte_count got %0d exp %0d", byte_cnt, NBYTES); end
        if (spi_cs_n !== 1'b1)   begin failures++; $display("FAIL zero_cs_n_end got %b exp 1", spi_cs_n); end
        if (fd_cs_err != 0)      begin failures++; $display("FAIL zero_fd_cs got %0d exp 0", fd_cs_err); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_byte[i] !== cmd_tab[i] || cap_dc[i] !== 1'b0) begin
                failures++;
                $display("FAIL zero_cmd[%0d] got %h/dc%b exp %h/dc0", i, cap_byte[i], cap_dc[i], cmd_tab[i]);
            end
        end
        for (int i = 6; i < NBYTES; i++) begin
            checks++;
            if (cap_byte[i] !== 8'h00 || cap_dc[i] !== 1'b1) begin
                failures++;
                $display("FAIL zero_data[%0d] got %h/dc%b exp 00/dc1", i - 6, cap_byte[i], cap_dc[i]);
            end
        end
    endtask

    task automatic test_read_handshake();
        checks += 4;
        if (hs_err != 0)      begin failures++; $display("FAIL hs_protocol got %0d errors exp 0", hs_err); end
        if (win_cnt != 8)     begin failures++; $display("FAIL hs_busy_windows got %0d exp 8", win_cnt); end
        if (ack_total != 256) begin failures++; $display("FAIL hs_acks got %0d exp 256", ack_total); end
        if (spi_err != 0)     begin failures++; $display("FAIL sck_outside_cs got %0d exp 0", spi_err); end
    endtask

    task automatic test_reset_mid_frame();
        int a0, r0;
        bit ok;
        a0 = ack_total;
        pulse_refresh();
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (ack_total >= a0 + 128 && !scr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (200) @(negedge clk);
        checks += 2;
        if (!ok)               begin failures++; $display("FAIL midreset_reach_page3 got 0 exp 1"); end
        if (spi_cs_n !== 1'b0) begin failures++; $display("FAIL midreset_active_cs_n got %b exp 0", spi_cs_n); end
        reset = 1'b1;
        #1;
        checks += 4;
        if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL midreset_cs_n got %b exp 1", spi_cs_n); end
        if (spi_sck !== 1'b0)  begin failures++; $display("FAIL midreset_sck got %b exp 0", spi_sck); end
        if (scr_read !== 1'b0) begin failures++; $display("FAIL midreset_read got %b exp 0", scr_read); end
        if (scr_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b exp 0", scr_busy); end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        r0 = sck_rises;
        repeat (300) @(negedge clk);
        checks += 3;
        if (sck_rises != r0)   begin failures++; $display("FAIL midreset_sck_edges got %0d exp %0d", sck_rises, r0); end
        if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL midreset_idle_cs_n got %b exp 1", spi_cs_n); end
        if (scr_read !== 1'b0) begin failures++; $display("FAIL midreset_idle_read got %b exp 0", scr_read); end
    endtask

    task automatic test_pattern_frame();
        int fd0, a0, idx;
        bit ok;
        logic [7:0] exp_b;
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        fb[0]   = 8'h80;   // pixel (0,0)
        fb[8]   = 8'hFF;   // row 1, x 0..7
        fb[255] = 8'h01;   // pixel (63,31)
        fd0 = fd_cnt;
        a0 = ack_total;
        pulse_refresh();
        wait_fd(45000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL pat_frame_timeout got 0 exp 1"); end
        repeat (50) @(negedge clk);
        checks += 5;
        if (fd_cnt != fd0 + 1)      begin failures++; $display("FAIL pat_frame_count got %0d exp %0d", fd_cnt, fd0 + 1); end
        if (byte_cnt != NBYTES)     begin failures++; $display("FAIL pat_byte_count got %0d exp %0d", byte_cnt, NBYTES); end
        if (ack_total != a0 + 256)  begin failures++; $display("FAIL pat_acks got %0d exp %0d", ack_total - a0, 256); end
        if (hs_err != 0)            begin failures++; $display("FAIL pat_hs_protocol got %0d exp 0", hs_err); end
        if (fd_cs_err != 0)         begin failures++; $display("FAIL pat_fd_cs got %0d exp 0", fd_cs_err); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_byte[i] !== cmd_tab[i] || cap_dc[i] !== 1'b0) begin
                failures++;
                $display("FAIL pat_cmd[%0d] got %h/dc%b exp %h/dc0", i, cap_byte[i], cap_dc[i], cmd_tab[i]);
            end
        end
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 128; c++) begin
                if (p == 0 && c < 2)        exp_b = 8'h0F;
                else if (p == 0 && c < 16)  exp_b = 8'h0C;
                else if (p == 7 && c >= 126) exp_b = 8'hC0;
                else                        exp_b = 8'h00;
                idx = 6 + p * 128 + c;
                checks++;
                if (cap_byte[idx] !== exp_b || cap_dc[idx] !== 1'b1) begin
                    failures++;
                    $display("FAIL pat_data p%0d c%0d got %h/dc%b exp %h/dc1", p, c, cap_byte[idx], cap_dc[idx], exp_b);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
        test_reset();
        test_ready_low();
        test_zero_frame();
        test_read_handshake();
        test_reset_mid_frame();
        test_pattern_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
